prog_loader: RTL
================

Name: prog_loader

Overview:
- Upstream programming controller for the FPGA configuration scan chain (logic cluster followed by the output prog_mux chain).
- Accepts the bitstream as a byte stream with a valid/ready handshake.
- Serialises it onto prog_clk/prog_en/prog_in at a divided rate.
- Optional verify pass: re-streams the same bitstream and compares the returning prog_out against it, flagging any configuration corruption.

Parameters:
- CHAIN_LEN, 64, total configuration bits in the scan chain (exact chain length, >= 1).
- CLK_DIV, 2, clk cycles per prog_clk phase (low and high each last CLK_DIV cycles, >= 1).
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- verify  in  1  sampled with start; 1 = load pass followed by verify pass
- s_data  in  8  bitstream byte, MSB shifted first
- s_valid  in  1  s_data valid
- s_ready  out  1  byte accepted when s_valid & s_ready
- prog_clk  out  1  scan-chain shift clock
- prog_en  out  1  scan-chain enable
- prog_in  out  1  serial configuration data
- prog_out  in  1  chain tail return data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- error  out  1  sticky mismatch flag, cleared on the next accepted start
- err_count  out  ERR_W  saturating mismatch count, cleared on the next accepted start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Pass structure: each pass consumes NBYTES = ceil(CHAIN_LEN/8) bytes. Only the first CHAIN_LEN bits of a pass are shifted. Unused low-order bits of the final byte are discarded.
- FSM states: IDLE, FETCH, LO, HI, DRAIN, DONE.
- IDLE: on start, latch verify, clear error/err_count, go to FETCH. In all other states, start is ignored.
- FETCH: s_ready=1, prog_en=1, prog_clk=0. Holds indefinitely while s_valid=0 (stall-safe; prog_clk stays low). On handshake, load the byte into the shift register and go to LO.
- LO: prog_clk=0 for CLK_DIV cycles; prog_in = current bit from the first LO cycle. In verify pass only, prog_out is sampled on the last LO cycle. Then go to HI.
- HI: prog_clk=1 for CLK_DIV cycles. Bit counter increments on exit. Transitions on exit:
  - pass bit count reached CHAIN_LEN: go to DRAIN;
  - byte exhausted: go to FETCH;
  - otherwise: go to LO with the next bit.
- Verify compare: bit i of the verify pass is compared against prog_out. A mismatch sets error and increments err_count, which saturates at all ones.
- DRAIN: prog_clk=0, prog_en=1 for CLK_DIV cycles. Then go to FETCH if verify latched and the first pass is done; otherwise go to DONE.
- DONE: done=1 for one cycle, prog_en=0, busy=0, return to IDLE.
- prog_en is high from FETCH entry through the end of DRAIN. It never drops while prog_in may toggle, because the downstream rst decode is prog_in & !prog_en.
- Per-bit latency: 2*CLK_DIV cycles, plus stall cycles and one FETCH cycle per byte.
- rst mid-operation: immediate return to IDLE; prog_en, prog_clk and s_ready low the next cycle; no done pulse; partial chain contents undefined.
- CHAIN_LEN divisible by 8: no discarded bits. CHAIN_LEN < 8: single byte per pass.

Decomposition:
- Shared package prog_loader_pkg holds:
  - state enum;
  - localparam NBYTES;
  - localparam BIT_CNT_W = $clog2(CHAIN_LEN+1);
  - localparam DIV_CNT_W = $clog2(CLK_DIV+1).
- One sub-module, prog_serializer: byte shift register, phase counter and prog_clk/prog_in generation, with a bit_done strobe back to the FSM.

Test Plan:
- CHAIN_LEN=12, CLK_DIV=2, verify=0, bytes 0xA5,0x3F with s_valid held high:
  - prog_in = 1,0,1,0,0,1,0,1,0,0,1,1 on 12 rising prog_clk edges;
  - 0x3F low nibble discarded;
  - done after DRAIN; prog_en never low while busy.
- Same load with s_valid dropped for 7 cycles before the second byte:
  - prog_clk held low and prog_en held high during the stall;
  - identical bit sequence; total duration grows by 7 cycles.
- Behavioural 12-bit shift-register chain model, verify=1, bytes 0xA5,0x3F streamed twice:
  - error=0, err_count=0, exactly one done pulse.
- Chain model with one bit forced (bit 4 stuck at 1):
  - error=1, err_count=1 after done.
- rst asserted mid-HI of bit 6:
  - next cycle prog_en=0, prog_clk=0, busy=0, no done pulse;
  - a new start loads cleanly.
- start pulsed while busy:
  - ignored; error/err_count not cleared; exactly one done pulse.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
// Modules derive their own widths from their parameters; the values here describe the default build.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LO,
    HI,
    DRAIN,
    DONE
  } state_t;

  localparam int CHAIN_LEN_DEF = 64;
  localparam int CLK_DIV_DEF   = 2;
  localparam int ERR_W_DEF     = 8;

  localparam int NBYTES    = (CHAIN_LEN_DEF + 7) / 8;
  localparam int BIT_CNT_W = $clog2(CHAIN_LEN_DEF + 1);
  localparam int DIV_CNT_W = $clog2(CLK_DIV_DEF + 1);

endpackage

// File: rtl/prog_serializer.sv
// Byte shift register and prog_clk phase timing for the configuration chain.
// Reports phase ends and the end of each shifted bit back to the controlling FSM.
module prog_serializer
  import prog_loader_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DIV_W   = DIV_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  state_t     state,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       phase_end,
  output logic       bit_done,
  output logic       byte_end,
  output logic       prog_clk,
  output logic       prog_in
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       sh_p0;
  logic             run;
  logic             bit_active;

  assign run        = (state == LO) || (state == HI) || (state == DRAIN);
  assign bit_active = (state == LO) || (state == HI);
  assign phase_end  = run && (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign bit_done   = (state == HI) && phase_end;
  assign byte_end   = bit_done && (bit_idx_q == 3'd7);

  // Each timed state starts from zero, so the counter wraps at every phase end.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (!run || phase_end) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_q <= '0;
    end else if (load) begin
      bit_idx_q <= '0;
    end else if (bit_done) begin
      bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

  // Stage p0: byte held MSB-first, advanced once per completed bit
  always_ff @(posedge clk) begin
    if (load) begin
      sh_p0 <= load_data;
    end else if (bit_done) begin
      sh_p0 <= {sh_p0[6:0], 1'b0};
    end
  end

  assign prog_clk = (state == HI);
  // Forced low outside a bit slot so no stale data appears while idle.
  assign prog_in  = bit_active && sh_p0[7];

endmodule

// File: rtl/prog_loader.sv
// Streams a byte-wide bitstream onto the configuration scan chain at a divided clock,
// with an optional second pass that reads the chain back and counts mismatches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int ERR_W     = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             verify,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             prog_clk,
  output logic             prog_en,
  output logic             prog_in,
  input  logic             prog_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [ERR_W-1:0] err_count
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t           state_q, state_nx;
  logic             verify_q;
  logic             second_q;
  logic             error_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;

  logic start_acc;
  logic load;
  logic phase_end;
  logic bit_done;
  logic byte_end;
  logic last_bit;
  logic mismatch;

  assign start_acc = (state_q == IDLE) && start;
  assign load      = (state_q == FETCH) && s_valid;
  assign last_bit  = (bit_cnt_q == BIT_W'(CHAIN_LEN - 1));
  // Sampled just before the rising edge: the tail still presents the bit now on prog_in.
  assign mismatch  = (state_q == LO) && phase_end && second_q && (prog_out != prog_in);

  prog_serializer #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .state     (state_q),
    .load      (load),
    .load_data (s_data),
    .phase_end (phase_end),
    .bit_done  (bit_done),
    .byte_end  (byte_end),
    .prog_clk  (prog_clk),
    .prog_in   (prog_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (s_valid) state_nx = LO;
      LO:      if (phase_end) state_nx = HI;
      HI: begin
        if (bit_done) begin
          if (last_bit) begin
            state_nx = DRAIN;
          end else if (byte_end) begin
            state_nx = FETCH;
          end else begin
            state_nx = LO;
          end
        end
      end
      DRAIN: begin
        if (phase_end) begin
          state_nx = (verify_q && !second_q) ? FETCH : DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pass bookkeeping: bit position within the pass and which pass is running
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      second_q  <= 1'b0;
      verify_q  <= 1'b0;
    end else if (start_acc) begin
      bit_cnt_q <= '0;
      second_q  <= 1'b0;
      verify_q  <= verify;
    end else begin
      if (bit_done) begin
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BIT_W'(1);
      end
      if ((state_q == DRAIN) && phase_end) begin
        second_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (start_acc) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (mismatch) begin
      error_q   <= 1'b1;
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  // prog_en spans FETCH..DRAIN so prog_in never toggles while the chain could decode a reset.
  assign s_ready   = (state_q == FETCH);
  assign prog_en   = (state_q == FETCH) || (state_q == LO) ||
                     (state_q == HI)    || (state_q == DRAIN);
  assign busy      = prog_en;
  assign done      = (state_q == DONE);
  assign error     = error_q;
  assign err_count = err_cnt_q;

endmodule
